// File: rtl/instruction_issue_unit.sv
// rtl/instruction_issue_unit.sv - prefetch FIFO and COMMAND history issue stage for the decoder
// Optional load-use interlock enabled by defining LOAD_USE_STALL_EN.
module instruction_issue_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] NOP_WORD = 16'hC0E0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    output logic        imem_ready,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] COMMAND,
    output logic [15:0] BeforeCOMMAND,
    output logic [15:0] TwoBeforeCOMMAND,
    output logic        issue_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [15:0]   before_q, before_d;
    logic [15:0]   two_before_q, two_before_d;
    logic          issue_valid_q, issue_valid_d;

    logic [15:0]   head_word;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          load_use;

    assign head_word  = mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign imem_ready = (count_q < CW'(DEPTH));
    assign push       = imem_valid && imem_ready && !flush;

`ifdef LOAD_USE_STALL_EN
    // True when the instruction word consumes register r as a source operand.
    function automatic logic reads_reg(input logic [15:0] w, input logic [2:0] r);
        logic hit;
        hit = 1'b0;
        case (w[15:14])
            2'b01:   hit = (w[10:8] == r);
            2'b11:   hit = ((w[7:4] <= 4'b0110) || (w[7:4] == 4'b1101)) && (w[10:8] == r);
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    assign load_use = !fifo_empty && (cmd_q[15:14] == 2'b00) && reads_reg(head_word, cmd_q[13:11]);
`else
    assign load_use = 1'b0;
`endif

    assign pop = !flush && !stall && !fifo_empty && !load_use;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Flush still shifts history so the taken branch remains visible to forwarding.
    always_comb begin
        cmd_d         = cmd_q;
        before_d      = before_q;
        two_before_d  = two_before_q;
        issue_valid_d = issue_valid_q;
        if (flush) begin
            two_before_d  = before_q;
            before_d      = cmd_q;
            cmd_d         = NOP_WORD;
            issue_valid_d = 1'b0;
        end else if (!stall) begin
            two_before_d = before_q;
            before_d     = cmd_q;
            if (pop) begin
                cmd_d         = head_word;
                issue_valid_d = 1'b1;
            end else begin
                cmd_d         = NOP_WORD;
                issue_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= imem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            cmd_q         <= NOP_WORD;
            before_q      <= NOP_WORD;
            two_before_q  <= NOP_WORD;
            issue_valid_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            cmd_q         <= cmd_d;
            before_q      <= before_d;
            two_before_q  <= two_before_d;
            issue_valid_q <= issue_valid_d;
        end
    end

    assign COMMAND          = cmd_q;
    assign BeforeCOMMAND    = before_q;
    assign TwoBeforeCOMMAND = two_before_q;
    assign issue_valid      = issue_valid_q;

endmodule

// File: tb/tb_instruction_issue_unit.sv
// tb/tb_instruction_issue_unit.sv - scoreboard bench for instruction_issue_unit
// Define LOAD_USE_STALL_EN consistently for bench and RTL to check the interlock build.
module tb_instruction_issue_unit;

    localparam logic [15:0] NOP = 16'hC0E0;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        imem_ready;
    logic        stall;
    logic        flush;
    logic [15:0] COMMAND;
    logic [15:0] BeforeCOMMAND;
    logic [15:0] TwoBeforeCOMMAND;
    logic        issue_valid;

    int total;
    int bad;
    logic [15:0] exp_q[$];

    instruction_issue_unit #(.DEPTH(4), .NOP_WORD(NOP)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_data        (imem_data),
        .imem_valid       (imem_valid),
        .imem_ready       (imem_ready),
        .stall            (stall),
        .flush            (flush),
        .COMMAND          (COMMAND),
        .BeforeCOMMAND    (BeforeCOMMAND),
        .TwoBeforeCOMMAND (TwoBeforeCOMMAND),
        .issue_valid      (issue_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_valid = 1'b1; imem_data = 16'h1234; stall = 1'b0; flush = 1'b0;
        step();
        step();
        total++; if (COMMAND !== NOP) begin bad++; $display("FAIL reset_cmd got=%h want=%h", COMMAND, NOP); end
        total++; if (BeforeCOMMAND !== NOP) begin bad++; $display("FAIL reset_before got=%h want=%h", BeforeCOMMAND, NOP); end
        total++; if (TwoBeforeCOMMAND !== NOP) begin bad++; $display("FAIL reset_two got=%h want=%h", TwoBeforeCOMMAND, NOP); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", issue_valid); end
        total++; if (imem_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", imem_ready); end
        imem_valid = 1'b0;
        rst_n = 1'b1;
        step();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_nostore got=%b want=0", issue_valid); end
    endtask

    task automatic test_issue_pair();
        logic [15:0] e;
        imem_valid = 1'b1; imem_data = 16'h8105; exp_q.push_back(16'h8105);
        step();
        total++; if (COMMAND !== NOP || issue_valid !== 1'b0) begin bad++; $display("FAIL pair_bubble got=%h/%b want=%h/0", COMMAND, issue_valid, NOP); end
        imem_data = 16'hC150; exp_q.push_back(16'hC150);
        step();
        imem_valid = 1'b0;
        e = exp_q.pop_front();
        total++; if (COMMAND !== e || issue_valid !== 1'b1) begin bad++; $display("FAIL pair_a got=%h/%b want=%h/1", COMMAND, issue_valid, e); end
        step();
        e = exp_q.pop_front();
        total++; if (COMMAND !== e || issue_valid !== 1'b1) begin bad++; $display("FAIL pair_b got=%h/%b want=%h/1", COMMAND, issue_valid, e); end
        total++; if (BeforeCOMMAND !== 16'h8105) begin bad++; $display("FAIL pair_before got=%h want=8105", BeforeCOMMAND); end
        total++; if (TwoBeforeCOMMAND !== NOP) begin bad++; $display("FAIL pair_two got=%h want=%h", TwoBeforeCOMMAND, NOP); end
    endtask

    task automatic test_fill_stall();
        logic [15:0] e;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (imem_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%b want=1", i, imem_ready); end
            imem_valid = 1'b1; imem_data = 16'h4100 + 16'(i); exp_q.push_back(imem_data);
            step();
        end
        total++; if (imem_ready !== 1'b0) begin bad++; $display("FAIL fill_full got=%b want=0", imem_ready); end
        imem_data = 16'hDEAD;
        step();
        imem_valid = 1'b0;
        total++; if (COMMAND !== 16'hC150 || issue_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%b want=c150/1", COMMAND, issue_valid); end
        total++; if (BeforeCOMMAND !== 16'h8105) begin bad++; $display("FAIL stall_before got=%h want=8105", BeforeCOMMAND); end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            e = exp_q.pop_front();
            total++; if (COMMAND !== e || issue_valid !== 1'b1) begin bad++; $display("FAIL drain%0d got=%h/%b want=%h/1", i, COMMAND, issue_valid, e); end
        end
        step();
        total++; if (COMMAND !== NOP || issue_valid !== 1'b0) begin bad++; $display("FAIL drain_extra got=%h/%b want=%h/0", COMMAND, issue_valid, NOP); end
    endtask

    task automatic test_flush();
        logic [15:0] e;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_valid = 1'b1; imem_data = 16'h4A00 + 16'(i); exp_q.push_back(imem_data);
            step();
        end
        imem_valid = 1'b0; stall = 1'b0;
        step();
        e = exp_q.pop_front();
        total++; if (COMMAND !== e) begin bad++; $display("FAIL preflush got=%h want=%h", COMMAND, e); end
        flush = 1'b1; stall = 1'b1; imem_valid = 1'b1; imem_data = 16'h5555;
        exp_q.delete();
        step();
        flush = 1'b0; stall = 1'b0; imem_valid = 1'b0;
        total++; if (COMMAND !== NOP || issue_valid !== 1'b0) begin bad++; $display("FAIL flush_cmd got=%h/%b want=%h/0", COMMAND, issue_valid, NOP); end
        total++; if (BeforeCOMMAND !== e) begin bad++; $display("FAIL flush_before got=%h want=%h", BeforeCOMMAND, e); end
        total++; if (imem_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", imem_ready); end
        step();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b want=0", issue_valid); end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 3; i++) step();
        total++; if (COMMAND !== NOP || BeforeCOMMAND !== NOP || TwoBeforeCOMMAND !== NOP) begin
            bad++; $display("FAIL empty_hist got=%h/%h/%h want=%h", COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND, NOP);
        end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%b want=0", issue_valid); end
    endtask

    task automatic test_reset_stall();
        imem_valid = 1'b1; imem_data = 16'h7777;
        step();
        imem_valid = 1'b0;
        step();
        total++; if (COMMAND !== 16'h7777) begin bad++; $display("FAIL rs_pre got=%h want=7777", COMMAND); end
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_valid = 1'b1; imem_data = 16'h6000 + 16'(i);
            step();
        end
        imem_valid = 1'b0;
        total++; if (imem_ready !== 1'b0) begin bad++; $display("FAIL rs_full got=%b want=0", imem_ready); end
        rst_n = 1'b0;
        step();
        total++; if (COMMAND !== NOP || BeforeCOMMAND !== NOP || TwoBeforeCOMMAND !== NOP) begin
            bad++; $display("FAIL rs_hist got=%h/%h/%h want=%h", COMMAND, BeforeCOMMAND, TwoBeforeCOMMAND, NOP);
        end
        total++; if (imem_ready !== 1'b1) begin bad++; $display("FAIL rs_ready got=%b want=1", imem_ready); end
        rst_n = 1'b1; stall = 1'b0;
        step();
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL rs_cleared got=%b want=0", issue_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        int sent;
        sent = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (sent < 10 && imem_ready) begin
                imem_valid = 1'b1;
                imem_data  = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
                exp_q.push_back(imem_data);
                sent++;
            end else begin
                imem_valid = 1'b0;
            end
            step();
            if (issue_valid) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                total++; if (COMMAND !== e) begin bad++; $display("FAIL b2b got=%h want=%h", COMMAND, e); end
            end
            if (sent == 10 && exp_q.size() == 0) break;
        end
        imem_valid = 1'b0;
        total++; if (exp_q.size() != 0 || sent != 10) begin bad++; $display("FAIL b2b_timeout left=%0d want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_load_use();
        imem_valid = 1'b1; imem_data = 16'h1A02;
        step();
        imem_data = 16'hC308;
        step();
        imem_valid = 1'b0;
        total++; if (COMMAND !== 16'h1A02) begin bad++; $display("FAIL lu_load got=%h want=1a02", COMMAND); end
        step();
`ifdef LOAD_USE_STALL_EN
        total++; if (COMMAND !== NOP || issue_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%h/%b want=%h/0", COMMAND, issue_valid, NOP); end
        step();
`endif
        total++; if (COMMAND !== 16'hC308 || issue_valid !== 1'b1) begin bad++; $display("FAIL lu_use got=%h/%b want=c308/1", COMMAND, issue_valid); end
        total++; if (BeforeCOMMAND !== ((`ifdef LOAD_USE_STALL_EN NOP `else 16'h1A02 `endif))) begin
            bad++; $display("FAIL lu_before got=%h", BeforeCOMMAND);
        end
        step();
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; imem_data = '0; imem_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        test_reset();
        test_issue_pair();
        test_fill_stall();
        test_flush();
        test_empty();
        test_reset_stall();
        test_back_to_back();
        test_load_use();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
